// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared 8N1 frame constants and receiver state encoding for the UART blocks.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned UART_STOP_BITS = 1;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        RX_START_BIT = 3'd1,
        RX_DATA_BITS = 3'd2,
        RX_STOP_BIT  = 3'd3,
        CLEANUP      = 3'd4,
        WAIT_IDLE    = 3'd5
    } uart_rx_state_e;

    // Offset of the mid-bit sample point inside the start bit.
    function automatic logic [15:0] uart_half_bit(input int unsigned clks_per_bit);
        return 16'((clks_per_bit - 1) / 2);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop single-bit synchronizer with a configurable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_D,
    output logic o_Q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= i_D;
            sync_q <= meta_q;
        end
    end

    assign o_Q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver: mid-bit sampling FSM with framing-error detection.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10416
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Frame_Err
);

    localparam logic [15:0] HALF     = uart_half_bit(CLKS_PER_BIT);
    localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_IDX = 3'(UART_DATA_BITS - 1);

    logic           r_Rx;
    uart_rx_state_e state_q;
    logic [15:0]    clk_cnt_q;
    logic [2:0]     bit_idx_q;
    logic [7:0]     shift_q;
    logic [7:0]     rx_byte_q;
    logic           rx_dv_q;
    logic           frame_err_q;
    logic           rx_active_q;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .i_Clock(i_Clock),
        .i_Rst_n(i_Rst_n),
        .i_D    (i_Rx_Serial),
        .o_Q    (r_Rx)
    );

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= IDLE;
            clk_cnt_q   <= 16'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            rx_byte_q   <= 8'h00;
            rx_dv_q     <= 1'b0;
            frame_err_q <= 1'b0;
            rx_active_q <= 1'b0;
        end else begin
            rx_dv_q     <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    clk_cnt_q <= 16'd0;
                    bit_idx_q <= 3'd0;
                    if (!r_Rx) begin
                        state_q <= RX_START_BIT;
                    end
                end
                // A low that does not survive to mid-start is treated as line noise.
                RX_START_BIT: begin
                    if (clk_cnt_q == HALF) begin
                        clk_cnt_q <= 16'd0;
                        if (!r_Rx) begin
                            rx_active_q <= 1'b1;
                            state_q     <= RX_DATA_BITS;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 16'd1;
                    end
                end
                RX_DATA_BITS: begin
                    if (clk_cnt_q == LAST_CLK) begin
                        clk_cnt_q          <= 16'd0;
                        shift_q[bit_idx_q] <= r_Rx;
                        if (bit_idx_q == LAST_IDX) begin
                            bit_idx_q <= 3'd0;
                            state_q   <= RX_STOP_BIT;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 16'd1;
                    end
                end
                RX_STOP_BIT: begin
                    if (clk_cnt_q == LAST_CLK) begin
                        clk_cnt_q <= 16'd0;
                        if (r_Rx) begin
                            rx_byte_q <= shift_q;
                            rx_dv_q   <= 1'b1;
                            state_q   <= CLEANUP;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_IDLE;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 16'd1;
                    end
                end
                CLEANUP: begin
                    rx_active_q <= 1'b0;
                    state_q     <= IDLE;
                end
                // A break holds the line low; the next start edge is only meaningful after it rises.
                WAIT_IDLE: begin
                    if (r_Rx) begin
                        rx_active_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_Rx_DV     = rx_dv_q;
    assign o_Rx_Byte   = rx_byte_q;
    assign o_Rx_Active = rx_active_q;
    assign o_Frame_Err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a frame-level model.
module tb_uart_rx;

    localparam int C    = 16;
    localparam int H    = (C - 1) / 2;
    localparam int BASE = H + 9 * C;

    typedef struct {
        bit       fe;
        bit [7:0] data;
        int       start;
    } ev_t;

    logic       i_Clock = 1'b0;
    logic       i_Rst_n = 1'b0;
    logic       i_Rx_Serial = 1'b1;
    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;
    logic       o_Rx_Active;
    logic       o_Frame_Err;

    int       total = 0;
    int       bad = 0;
    int       cyc = 0;
    ev_t      exp_q[$];
    int       dv_hist[$];
    bit [7:0] model_byte = 8'h00;
    int       last_dv = -1000;
    int       high_run = 0;
    bit       glitch_win = 1'b0;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .i_Clock    (i_Clock),
        .i_Rst_n    (i_Rst_n),
        .i_Rx_Serial(i_Rx_Serial),
        .o_Rx_DV    (o_Rx_DV),
        .o_Rx_Byte  (o_Rx_Byte),
        .o_Rx_Active(o_Rx_Active),
        .o_Frame_Err(o_Frame_Err)
    );

    always #5 i_Clock = ~i_Clock;
    always @(posedge i_Clock) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Frame-level reference: every pulse must match the oldest outstanding frame.
    always @(negedge i_Clock) begin
        if (!i_Rst_n) begin
            model_byte = 8'h00;
            last_dv    = -1000;
            high_run   = 0;
        end else begin
            high_run = i_Rx_Serial ? high_run + 1 : 0;
            if (o_Rx_DV || o_Frame_Err) begin
                ev_t e;
                check("dv_fe_exclusive", int'(o_Rx_DV && o_Frame_Err), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind_is_fe", int'(o_Frame_Err), int'(e.fe));
                    check("latency_in_window",
                          int'((cyc - e.start - BASE) >= 2 && (cyc - e.start - BASE) <= 5), 1);
                    if (o_Rx_DV && !e.fe) begin
                        model_byte = e.data;
                        last_dv    = cyc;
                        dv_hist.push_back(cyc);
                    end
                end
            end
            check("rx_byte", int'(o_Rx_Byte), int'(model_byte));
            if (cyc == last_dv + 3) check("active_falls_after_dv", int'(o_Rx_Active), 0);
            if (high_run >= 10 * C) check("active_idle_line", int'(o_Rx_Active), 0);
            if (glitch_win) begin
                check("glitch_active", int'(o_Rx_Active), 0);
            end
        end
    end

    task automatic hold(input logic v, input int n);
        i_Rx_Serial = v;
        repeat (n) @(posedge i_Clock);
        #1;
    endtask

    task automatic send_frame(input bit [7:0] data, input bit stop_ok, input int extra_low);
        ev_t e;
        e.fe = !stop_ok;
        e.data = data;
        e.start = cyc;
        exp_q.push_back(e);
        hold(1'b0, C);
        for (int i = 0; i < 8; i++) hold(data[i], C);
        if (stop_ok) hold(1'b1, C);
        else hold(1'b0, C + extra_low);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge i_Clock);
            n++;
        end
        #1;
        check("drain_outstanding", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int pulses0;
        #3;
        check("reset_dv", int'(o_Rx_DV), 0);
        check("reset_byte", int'(o_Rx_Byte), 0);
        check("reset_active", int'(o_Rx_Active), 0);
        check("reset_fe", int'(o_Frame_Err), 0);
        repeat (3) @(posedge i_Clock);
        #1;
        i_Rst_n = 1'b1;
        hold(1'b1, 20);

        send_frame(8'hA5, 1'b1, 0);
        hold(1'b1, 20);
        wait_drain(200);
        check("byte_A5_literal", int'(o_Rx_Byte), 8'hA5);

        pulses0 = dv_hist.size();
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        hold(1'b1, 20);
        wait_drain(200);
        check("b2b_two_pulses", dv_hist.size() - pulses0, 2);
        if (dv_hist.size() - pulses0 == 2) begin
            check("b2b_spacing_160", int'((dv_hist[pulses0 + 1] - dv_hist[pulses0]) >= 158 &&
                                          (dv_hist[pulses0 + 1] - dv_hist[pulses0]) <= 162), 1);
        end
        check("byte_FF_literal", int'(o_Rx_Byte), 8'hFF);

        glitch_win = 1'b1;
        hold(1'b0, 5);
        hold(1'b1, 40);
        glitch_win = 1'b0;
        send_frame(8'h3C, 1'b1, 0);
        hold(1'b1, 20);
        wait_drain(200);
        check("byte_3C_after_glitch", int'(o_Rx_Byte), 8'h3C);

        hold(1'b1, 20);
        send_frame(8'h3C, 1'b0, 100);
        check("break_active_high", int'(o_Rx_Active), 1);
        check("break_byte_kept", int'(o_Rx_Byte), 8'h3C);
        hold(1'b1, 10);
        check("break_active_cleared", int'(o_Rx_Active), 0);
        wait_drain(10);
        send_frame(8'h5A, 1'b1, 0);
        hold(1'b1, 20);
        wait_drain(200);
        check("byte_5A_after_break", int'(o_Rx_Byte), 8'h5A);

        hold(1'b0, C);
        for (int i = 0; i < 4; i++) hold(((8'h81 >> i) & 8'h01) != 0, C);
        i_Rx_Serial = 1'b0;
        repeat (8) @(posedge i_Clock);
        #3;
        i_Rst_n = 1'b0;
        #1;
        check("midframe_rst_dv", int'(o_Rx_DV), 0);
        check("midframe_rst_byte", int'(o_Rx_Byte), 0);
        check("midframe_rst_active", int'(o_Rx_Active), 0);
        check("midframe_rst_fe", int'(o_Frame_Err), 0);
        @(posedge i_Clock);
        #1;
        hold(1'b1, 5);
        i_Rst_n = 1'b1;
        hold(1'b1, 20);
        send_frame(8'h81, 1'b1, 0);
        hold(1'b1, 20);
        wait_drain(200);
        check("byte_81_after_reset", int'(o_Rx_Byte), 8'h81);

        for (int k = 0; k < 40; k++) begin
            bit [7:0] d;
            bit ok;
            d  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 5) != 0);
            send_frame(d, ok, ok ? 0 : int'($urandom_range(0, 30)));
            if (ok) hold(1'b1, int'($urandom_range(0, 1)) * int'($urandom_range(0, 20)));
            else hold(1'b1, int'($urandom_range(5, 25)));
        end
        hold(1'b1, 30);
        wait_drain(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, bad=%0d", bad);
        $fatal(1);
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10416, clock cycles per bit (100 MHz / 9600 baud); legal range 4..65535.
REQ-002 SHALL have port i_Clock  input  1  single clock; all flops on rising edge.
REQ-003 SHALL have port i_Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_Rx_Serial  input  1  asynchronous serial line; idles high.
REQ-005 SHALL have port o_Rx_DV  output  1  one-cycle pulse; o_Rx_Byte valid, good stop bit.
REQ-006 SHALL have port o_Rx_Byte  output  8  last received byte; held until next completed frame.
REQ-007 SHALL have port o_Rx_Active  output  1  high from validated start bit until return to IDLE.
REQ-008 SHALL have port o_Frame_Err  output  1  one-cycle pulse; stop bit sampled low.

Function
REQ-009 SHALL use frame format 8N1: start bit 0, 8 data bits LSB first, one stop bit 1, no parity.
REQ-010 SHALL pass i_Rx_Serial through a 2-flop synchronizer, reset to 1; the FSM SHALL use only the synchronized bit r_Rx.
REQ-011 SHALL implement states IDLE, RX_START_BIT, RX_DATA_BITS, RX_STOP_BIT, CLEANUP, WAIT_IDLE.
REQ-012 IDLE: clear bit counter and bit index; go to RX_START_BIT when r_Rx==0.
REQ-013 RX_START_BIT: count to H=(CLKS_PER_BIT-1)/2 (integer division); at H, if r_Rx==0, clear counter, assert o_Rx_Active and go to RX_DATA_BITS; otherwise return to IDLE as a glitch with no output pulse.
REQ-014 RX_DATA_BITS: count CLKS_PER_BIT-1 cycles, then sample r_Rx into shift position r_Bit_Index and clear the counter; after index 7, go to RX_STOP_BIT.
REQ-015 RX_STOP_BIT: count CLKS_PER_BIT-1 cycles, then sample r_Rx.
REQ-016 RX_STOP_BIT, sample 1: load o_Rx_Byte, pulse o_Rx_DV, go to CLEANUP.
REQ-017 RX_STOP_BIT, sample 0: pulse o_Frame_Err, leave o_Rx_Byte unchanged, go to WAIT_IDLE.
REQ-018 CLEANUP: one cycle; deassert o_Rx_Active; go to IDLE.
REQ-019 WAIT_IDLE: stay while r_Rx==0 (break/stuck-low line); on r_Rx==1 deassert o_Rx_Active and go to IDLE; no new frame starts until then.
REQ-020 o_Rx_DV and o_Frame_Err SHALL each be high for exactly one cycle per frame, and never high together.
REQ-021 Latency: the o_Rx_DV/o_Frame_Err pulse SHALL begin H+9*CLKS_PER_BIT+N cycles after the i_Rx_Serial start edge, N in 2..5 (fixed per design).
REQ-022 Back-to-back frames: a start bit beginning immediately after the stop bit's nominal end SHALL be received with no loss; sampling at mid-stop leaves at least H cycles of margin.
REQ-023 Bit counter width SHALL be 16 bits; the counter SHALL never wrap within a frame.
REQ-024 Unused/illegal state encodings SHALL transition to IDLE on the next clock.

Reset
REQ-025 On i_Rst_n low, immediately and asynchronously: state=IDLE, counters=0, synchronizer flops=1, o_Rx_Byte=8'h00, o_Rx_DV=0, o_Frame_Err=0, o_Rx_Active=0.
REQ-026 Reset mid-frame SHALL abandon the frame with no output pulse; after release, reception SHALL resume at the next start edge.

Structure
REQ-027 State encodings and the 8N1 frame constants (data bits=8, stop bits=1) SHALL live in the shared uart_pkg, which uart_tx also uses.
REQ-028 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, reset value parameter), reusable elsewhere; the rest is one FSM module.

Verification (run with CLKS_PER_BIT=16; stimulus driven by uart_tx or a bit-accurate model)
REQ-029 Send 0xA5 -> exactly one o_Rx_DV pulse, o_Rx_Byte=0xA5, o_Frame_Err never high, o_Rx_Active falls within 3 cycles of the DV pulse.
REQ-030 Send 0x00 then 0xFF back-to-back, no idle gap -> two DV pulses, bytes 0x00 then 0xFF, pulses 160+-2 cycles apart.
REQ-031 Drive i_Rx_Serial low for 5 cycles then high -> no DV, no Frame_Err, o_Rx_Active stays 0; a following 0x3C is received correctly.
REQ-032 Send 0x3C with stop bit 0, line held low 100 cycles, then high -> one o_Frame_Err pulse, no DV, o_Rx_Byte keeps its prior value, o_Rx_Active high until the line rises; a following 0x5A is received.
REQ-033 Assert i_Rst_n low during data bit 4 of 0x81 -> all outputs at reset values within the same cycle, no pulse; after release, send 0x81 -> DV pulse with o_Rx_Byte=0x81.
